// File: rtl/rem_reconstruct_if.sv
// rem_reconstruct_if: start/busy/valid handshake plus operand and result bundle
interface rem_reconstruct_if #(parameter int W = 2);
    logic Start;
    logic [W:0] NumQ;
    logic [W:0] NumB;
    logic [W:0] NumR;
    logic Busy;
    logic Valid;
    logic [2*W:0] Res;
    logic zerF;
    logic negF;
    logic DZF;
    logic ErrF;
    modport master (output Start, NumQ, NumB, NumR, input Busy, Valid, Res, zerF, negF, DZF, ErrF);
    modport slave (input Start, NumQ, NumB, NumR, output Busy, Valid, Res, zerF, negF, DZF, ErrF);
endinterface

// File: rtl/rem_reconstruct.sv
// rem_reconstruct: rebuilds dividend A = Q*B + R from sign-magnitude quotient, divisor and remainder
module rem_reconstruct #(parameter int W = 2) (
    input logic clk,
    input logic rst_n,
    rem_reconstruct_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;
    state_t state, stateNext;
    logic pend;
    logic [W-1:0] qShift, magB, magR;
    logic [2*W-1:0] bShift, acc, mag;
    logic [CW-1:0] cnt;
    logic sQ, sB, sR, qNz;
    logic accept, divZero, err, resZero, sgn;
    logic validR, zerR, negR, dzR, errR;
    logic [2*W:0] resR;
    assign accept = bus.Start && !bus.Busy;
    assign divZero = magB == '0;
    assign err = (magR >= magB) || (qNz && magR != '0 && sR != (sQ ^ sB));
    assign mag = (divZero || err) ? '0 : acc;
    assign resZero = mag == '0;
    assign sgn = !resZero && (qNz ? sQ ^ sB : sR);
    assign bus.Busy = state != IDLE || pend || validR;
    assign bus.Valid = validR;
    assign bus.Res = resR;
    assign bus.zerF = zerR;
    assign bus.negF = negR;
    assign bus.DZF = dzR;
    assign bus.ErrF = errR;
    // state register; reset aborts any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= stateNext;
    end
    // sequencing: a one-cycle load slot after acceptance, W multiply steps, the remainder add, then publish
    always_comb begin
        stateNext = state == IDLE ? (pend ? MUL : IDLE) :
                    state == MUL ? (cnt == CW'(W - 1) ? ADD : MUL) :
                    state == ADD ? DONE : IDLE;
    end
    // operand capture, shift-add multiply, remainder add and result/flag publication
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            validR <= 1'b0;
            resR <= '0;
            zerR <= 1'b0;
            negR <= 1'b0;
            dzR <= 1'b0;
            errR <= 1'b0;
        end else begin
            pend <= accept;
            validR <= state == DONE;
            if (accept) begin
                qShift <= bus.NumQ[W-1:0];
                bShift <= {{W{1'b0}}, bus.NumB[W-1:0]};
                magB <= bus.NumB[W-1:0];
                magR <= bus.NumR[W-1:0];
                sQ <= bus.NumQ[W];
                sB <= bus.NumB[W];
                sR <= bus.NumR[W];
                qNz <= bus.NumQ[W-1:0] != '0;
                acc <= '0;
                cnt <= '0;
            end
            if (state == MUL) begin
                acc <= acc + (qShift[0] ? bShift : '0);
                qShift <= qShift >> 1;
                bShift <= bShift << 1;
                cnt <= cnt + 1'b1;
            end
            if (state == ADD) acc <= acc + {{W{1'b0}}, magR};
            if (state == DONE) begin
                resR <= {sgn, mag};
                zerR <= resZero;
                negR <= sgn;
                dzR <= divZero;
                errR <= err && !divZero;
            end
        end
    end
endmodule

// File: tb/tb_rem_reconstruct.sv
// tb_rem_reconstruct: table-driven scoreboard bench for rem_reconstruct (W=2)
module tb_rem_reconstruct;
    localparam int W = 2;
    localparam int NV = 15;
    typedef struct { logic [W:0] q; logic [W:0] b; logic [W:0] r; logic [2*W:0] res; logic [3:0] flg; } vec_t;
    typedef struct { int id; logic [2*W:0] res; logic [3:0] flg; int due; } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    vec_t vecs[NV];
    rem_reconstruct_if #(.W(W)) bus ();
    rem_reconstruct #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask
    task automatic issue(input vec_t v, input int id);
        exp_t e;
        e.id = id;
        e.res = v.res;
        e.flg = v.flg;
        e.due = cyc + 1 + W + 3;
        sb.push_back(e);
        bus.Start = 1'b1;
        bus.NumQ = v.q;
        bus.NumB = v.b;
        bus.NumR = v.r;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask
    task automatic collect();
        exp_t e;
        int t;
        t = 0;
        while (!bus.Valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        e = sb.pop_front();
        if (!bus.Valid) begin
            checks++;
            errors++;
            $display("FAIL timeout id=%0d no Valid within 30 cycles", e.id);
        end else begin
            check($sformatf("res_%0d", e.id), 32'(bus.Res), 32'(e.res));
            check($sformatf("flags_%0d", e.id), 32'({bus.zerF, bus.negF, bus.DZF, bus.ErrF}), 32'(e.flg));
            check($sformatf("latency_%0d", e.id), cyc, e.due);
            check($sformatf("busy_at_valid_%0d", e.id), 32'(bus.Busy), 1);
            @(negedge clk);
            check($sformatf("valid_pulse_%0d", e.id), 32'(bus.Valid), 0);
            check($sformatf("busy_drop_%0d", e.id), 32'(bus.Busy), 0);
        end
    endtask
    task automatic quiet(input string name, input logic [2*W:0] hold);
        int bad;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.Valid) bad++;
        end
        check({name, "_no_extra_valid"}, bad, 0);
        check({name, "_hold"}, 32'(bus.Res), 32'(hold));
    endtask
    initial begin
        vecs[0] = '{3'b010, 3'b011, 3'b001, 5'b00111, 4'b0000};
        vecs[1] = '{3'b101, 3'b011, 3'b110, 5'b10101, 4'b0100};
        vecs[2] = '{3'b000, 3'b110, 3'b000, 5'b00000, 4'b1000};
        vecs[3] = '{3'b000, 3'b010, 3'b101, 5'b10001, 4'b0100};
        vecs[4] = '{3'b011, 3'b100, 3'b001, 5'b00000, 4'b1010};
        vecs[5] = '{3'b001, 3'b010, 3'b011, 5'b00000, 4'b1001};
        vecs[6] = '{3'b001, 3'b001, 3'b101, 5'b00000, 4'b1001};
        vecs[7] = '{3'b011, 3'b011, 3'b010, 5'b01011, 4'b0000};
        vecs[8] = '{3'b111, 3'b111, 3'b110, 5'b00000, 4'b1001};
        vecs[9] = '{3'b111, 3'b011, 3'b110, 5'b11011, 4'b0100};
        vecs[10] = '{3'b110, 3'b111, 3'b000, 5'b00110, 4'b0000};
        vecs[11] = '{3'b100, 3'b011, 3'b110, 5'b10010, 4'b0100};
        vecs[12] = '{3'b011, 3'b011, 3'b000, 5'b01001, 4'b0000};
        vecs[13] = '{3'b000, 3'b101, 3'b100, 5'b00000, 4'b1000};
        vecs[14] = '{3'b001, 3'b000, 3'b011, 5'b00000, 4'b1010};
        bus.Start = 1'b0;
        bus.NumQ = '0;
        bus.NumB = '0;
        bus.NumR = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(bus.Busy), 0);
        check("reset_valid", 32'(bus.Valid), 0);
        check("reset_res", 32'(bus.Res), 0);
        check("reset_flags", 32'({bus.zerF, bus.negF, bus.DZF, bus.ErrF}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i], i);
            collect();
            @(negedge clk);
        end
        issue(vecs[0], 100);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.NumQ = vecs[7].q;
        bus.NumB = vecs[7].b;
        bus.NumR = vecs[7].r;
        @(negedge clk);
        bus.Start = 1'b0;
        collect();
        quiet("start_in_mul", vecs[0].res);
        issue(vecs[1], 101);
        repeat (W + 2) @(negedge clk);
        bus.Start = 1'b1;
        bus.NumQ = vecs[12].q;
        bus.NumB = vecs[12].b;
        bus.NumR = vecs[12].r;
        @(negedge clk);
        bus.Start = 1'b0;
        collect();
        quiet("start_in_done", vecs[1].res);
        issue(vecs[9], 102);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_back());
        check("abort_busy", 32'(bus.Busy), 0);
        check("abort_res", 32'(bus.Res), 0);
        check("abort_flags", 32'({bus.zerF, bus.negF, bus.DZF, bus.ErrF}), 0);
        quiet("abort", 5'b00000);
        issue(vecs[7], 103);
        collect();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
